// File: rtl/sr_div_pkg.sv
// Shared types and constants for the sr_div restoring divider.
// Result patterns are sized for the default width; narrower instances slice them.
package sr_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

  localparam logic [DEF_WIDTH-1:0] QUOT_ALL_ONES = {DEF_WIDTH{1'b1}};
  localparam logic [DEF_WIDTH-1:0] SIGNED_MIN    = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/sr_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the
// divisor and keep the difference only when it does not go negative.
module sr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_partial,
  output logic             q_bit
);

  localparam int PW = WIDTH + 1;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor_ext;

  // Trial subtract; a non-negative difference is the same as shifted >= divisor.
  always_comb begin
    shifted     = {partial, dividend_bit};
    divisor_ext = {2'b00, divisor};
    q_bit       = (shifted >= divisor_ext);
    if (q_bit) begin
      next_partial = PW'(shifted - divisor_ext);
    end else begin
      next_partial = PW'(shifted);
    end
  end

endmodule

// File: rtl/sr_div.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: fast path for divide by
// zero and signed overflow, otherwise WIDTH iterations plus one sign-fix cycle.
module sr_div
  import sr_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] all_ones   = QUOT_ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] signed_min = SIGNED_MIN[DEF_WIDTH-1 -: WIDTH];
  localparam logic [CW-1:0]    last_iter  = CW'(WIDTH - 1);

  state_t           state_r, state_s;
  logic [CW-1:0]    count_r, count_s;
  logic [WIDTH:0]   prem_r, prem_s;
  logic [WIDTH-1:0] dvd_r, dvd_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic             sgn_r, sgn_s;
  logic             neg_a_r, neg_a_s;
  logic             neg_b_r, neg_b_s;
  logic [WIDTH-1:0] quotient_s, remainder_s;
  logic             busy_s, done_s, dbz_s;

  logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0]   step_partial;
  logic             step_q;

  sr_div_step #(.WIDTH(WIDTH)) u_step (
    .partial      (prem_r),
    .dividend_bit (dvd_r[WIDTH-1]),
    .divisor      (dvs_r),
    .next_partial (step_partial),
    .q_bit        (step_q)
  );

  // Magnitudes only in signed mode; results take their signs back in FIX.
  assign abs_a = (op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign q_fix = (sgn_r && (neg_a_r ^ neg_b_r)) ? -dvd_r : dvd_r;
  assign r_fix = sgn_r && neg_a_r ? -prem_r[WIDTH-1:0] : prem_r[WIDTH-1:0];

  // Next-state and datapath decisions for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    prem_s      = prem_r;
    dvd_s       = dvd_r;
    dvs_s       = dvs_r;
    sgn_s       = sgn_r;
    neg_a_s     = neg_a_r;
    neg_b_s     = neg_b_r;
    quotient_s  = quotient;
    remainder_s = remainder;
    busy_s      = busy;
    done_s      = 1'b0;
    dbz_s       = div_by_zero;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (divisor == {WIDTH{1'b0}}) begin
            quotient_s  = all_ones;
            remainder_s = dividend;
            dbz_s       = 1'b1;
            done_s      = 1'b1;
          end else if (op_signed && (dividend == signed_min) && (divisor == all_ones)) begin
            quotient_s  = dividend;
            remainder_s = {WIDTH{1'b0}};
            dbz_s       = 1'b0;
            done_s      = 1'b1;
          end else begin
            state_s = CALC;
            count_s = {CW{1'b0}};
            prem_s  = {(WIDTH+1){1'b0}};
            dvd_s   = abs_a;
            dvs_s   = abs_b;
            sgn_s   = op_signed;
            neg_a_s = dividend[WIDTH-1];
            neg_b_s = divisor[WIDTH-1];
            busy_s  = 1'b1;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        prem_s  = step_partial;
        dvd_s   = {dvd_r[WIDTH-2:0], step_q};
        count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        if (count_r == last_iter) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX: begin
        quotient_s  = q_fix;
        remainder_s = r_fix;
        dbz_s       = 1'b0;
        done_s      = 1'b1;
        busy_s      = 1'b0;
        state_s     = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      prem_r      <= {(WIDTH+1){1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      sgn_r       <= 1'b0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      prem_r      <= prem_s;
      dvd_r       <= dvd_s;
      dvs_r       <= dvs_s;
      sgn_r       <= sgn_s;
      neg_a_r     <= neg_a_s;
      neg_b_r     <= neg_b_s;
      quotient    <= quotient_s;
      remainder   <= remainder_s;
      busy        <= busy_s;
      done        <= done_s;
      div_by_zero <= dbz_s;
    end
  end

endmodule

// File: tb/tb_sr_div.sv
// Self-checking bench for sr_div: directed cases from the divider's contract plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_sr_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int total = 0;
  int passed = 0;

  sr_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // RISC-V division rules computed with native integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z,
                                output int lat);
    int sa, sb;
    int unsigned ua, ub;
    sa = a; sb = b; ua = a; ub = b;
    z = 1'b0;
    lat = 33;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; lat = 0;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = ua / ub; r = ua % ub;
    end
  endfunction

  // Drives one start now, scrambles operands afterwards, waits (bounded) for done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output logic busy_ok);
    dividend = a; divisor = b; op_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; op_signed = 1'($urandom_range(0, 1));
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0)
      $display("FAIL reset_outputs: got q=%h r=%h b=%b d=%b z=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    else passed++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic();
    int lat; logic bok;
    do_op(32'd100, 32'd7, 1'b0, lat, bok);
    total++; if (quotient !== 32'd14) $display("FAIL u100_7_q: got %h want %h", quotient, 32'd14); else passed++;
    total++; if (remainder !== 32'd2) $display("FAIL u100_7_r: got %h want %h", remainder, 32'd2); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL u100_7_dbz: got %b want 0", div_by_zero); else passed++;
    total++; if (lat != 33) $display("FAIL u100_7_latency: got %0d want 33", lat); else passed++;
    total++; if (bok !== 1'b1) $display("FAIL u100_7_busy_high: got %b want 1", bok); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL u100_7_busy_at_done: got %b want 0", busy); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else passed++;
  endtask

  task automatic test_signed_basic();
    int lat; logic bok;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bok);
    total++; if (quotient !== 32'hFFFF_FFFD) $display("FAIL sm7_2_q: got %h want FFFFFFFD", quotient); else passed++;
    total++; if (remainder !== 32'hFFFF_FFFF) $display("FAIL sm7_2_r: got %h want FFFFFFFF", remainder); else passed++;
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bok);
    total++; if (quotient !== 32'hFFFF_FFFD) $display("FAIL s7_m2_q: got %h want FFFFFFFD", quotient); else passed++;
    total++; if (remainder !== 32'd1) $display("FAIL s7_m2_r: got %h want 1", remainder); else passed++;
    total++; if (lat != 33) $display("FAIL s7_m2_latency: got %0d want 33", lat); else passed++;
  endtask

  task automatic test_fast_path();
    int lat; logic bok;
    for (int m = 0; m < 2; m++) begin
      do_op(32'd5, 32'd0, 1'(m), lat, bok);
      total++; if (quotient !== 32'hFFFF_FFFF) $display("FAIL dbz_q mode%0d: got %h want FFFFFFFF", m, quotient); else passed++;
      total++; if (remainder !== 32'd5) $display("FAIL dbz_r mode%0d: got %h want 5", m, remainder); else passed++;
      total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag mode%0d: got %b want 1", m, div_by_zero); else passed++;
      total++; if (lat != 0) $display("FAIL dbz_latency mode%0d: got %0d want 0", m, lat); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL dbz_busy mode%0d: got %b want 0", m, busy); else passed++;
    end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bok);
    total++; if (quotient !== 32'h8000_0000) $display("FAIL ovf_q: got %h want 80000000", quotient); else passed++;
    total++; if (remainder !== 32'd0) $display("FAIL ovf_r: got %h want 0", remainder); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL ovf_dbz: got %b want 0", div_by_zero); else passed++;
    total++; if (lat != 0) $display("FAIL ovf_latency: got %0d want 0", lat); else passed++;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bok);
    total++; if (quotient !== 32'd0) $display("FAIL ovf_unsigned_q: got %h want 0", quotient); else passed++;
    total++; if (remainder !== 32'h8000_0000) $display("FAIL ovf_unsigned_r: got %h want 80000000", remainder); else passed++;
    total++; if (lat != 33) $display("FAIL ovf_unsigned_latency: got %0d want 33", lat); else passed++;
  endtask

  task automatic test_ignore_start();
    int lat;
    dividend = 32'hFFFF_FFFF; divisor = 32'd3; op_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (10) begin @(posedge clk); #1; lat++; end
    dividend = 32'd7; divisor = 32'd0; op_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    total++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL ignore_start_state: got busy=%b done=%b want busy=1 done=0", busy, done); else passed++;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 33) $display("FAIL ignore_start_latency: got %0d want 33", lat); else passed++;
    total++; if (quotient !== 32'h5555_5555) $display("FAIL ignore_start_q: got %h want 55555555", quotient); else passed++;
    total++; if (remainder !== 32'd0) $display("FAIL ignore_start_r: got %h want 0", remainder); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL ignore_start_dbz: got %b want 0", div_by_zero); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic bok; logic saw_done;
    dividend = 32'd1000; divisor = 32'd3; op_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0)
      $display("FAIL reset_mid_outputs: got q=%h r=%h b=%b d=%b z=%b want all 0",
               quotient, remainder, busy, done, div_by_zero); else passed++;
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
    total++; if (saw_done) $display("FAIL reset_mid_no_done: got activity=1 want 0"); else passed++;
    do_op(32'd81, 32'd9, 1'b0, lat, bok);
    total++; if (quotient !== 32'd9) $display("FAIL after_reset_q: got %h want 9", quotient); else passed++;
    total++; if (remainder !== 32'd0) $display("FAIL after_reset_r: got %h want 0", remainder); else passed++;
    total++; if (lat != 33) $display("FAIL after_reset_latency: got %0d want 33", lat); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; logic bok;
    do_op(32'd1000, 32'd10, 1'b0, lat, bok);
    total++; if (quotient !== 32'd100) $display("FAIL b2b_first_q: got %h want 100", quotient); else passed++;
    dividend = 32'hFFFF_FF9C; divisor = 32'd7; op_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || quotient !== 32'd100)
      $display("FAIL b2b_accept: got busy=%b q=%h want busy=1 q=100", busy, quotient); else passed++;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 33) $display("FAIL b2b_latency: got %0d want 33", lat); else passed++;
    total++; if (quotient !== 32'hFFFF_FFF2) $display("FAIL b2b_q: got %h want FFFFFFF2", quotient); else passed++;
    total++; if (remainder !== 32'hFFFF_FFFE) $display("FAIL b2b_r: got %h want FFFFFFFE", remainder); else passed++;
  endtask

  task automatic test_random();
    int lat, elat; logic bok; logic [31:0] a, b, eq, er; logic s, ez;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: b = -($urandom_range(1, 20));
        default: ;
      endcase
      model(a, b, s, eq, er, ez, elat);
      do_op(a, b, s, lat, bok);
      total++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat != elat)
        $display("FAIL random_%0d a=%h b=%h s=%b: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                 i, a, b, s, quotient, remainder, div_by_zero, lat, eq, er, ez, elat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_basic();
    test_fast_path();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
